// File: rtl/ibex_rf_writeback.sv
// Writeback arbiter in front of the flip-flop register file.
// Merges load responses and EX results onto the single write port. An EX result
// that loses the port to a load response is parked for one cycle in a skid buffer.
// A small in-order FIFO of outstanding load destinations drives the decode hazard stall.
module ibex_rf_writeback #(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LsuDepth  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_req_i,
  output logic                 lsu_req_ready_o,
  input  logic [4:0]           lsu_waddr_i,
  input  logic                 lsu_rvalid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  input  logic [4:0]           id_raddr_a_i,
  input  logic [4:0]           id_raddr_b_i,
  input  logic [4:0]           id_waddr_i,
  input  logic                 id_ra_used_i,
  input  logic                 id_rb_used_i,
  input  logic                 id_we_i,
  output logic                 id_stall_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 protocol_err_o
);

  localparam int unsigned PtrW = (LsuDepth > 1) ? $clog2(LsuDepth) : 1;

  // Register x0 (and, for RV32E, any address with bit 4 set) is never written nor tracked.
  function automatic logic is_zero(input logic [4:0] addr);
    return (addr == 5'd0) || (RV32E && addr[4]);
  endfunction

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(LsuDepth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  logic [4:0]           fifo_q [LsuDepth];
  logic [LsuDepth-1:0]  slot_vld_q, slot_vld_nxt;
  logic [PtrW-1:0]      rptr_q, wptr_q;
  logic                 buf_vld_q;
  logic [4:0]           buf_waddr_q;
  logic [DataWidth-1:0] buf_wdata_q;
  logic                 perr_q;

  logic                 fifo_empty, pop, push, buf_fill, we_raw;
  logic [31:0]          busy;

  assign fifo_empty      = ~|slot_vld_q;
  assign lsu_req_ready_o = ~&slot_vld_q;
  assign pop             = lsu_rvalid_i && !fifo_empty;
  assign push            = lsu_req_i && lsu_req_ready_o;
  assign ex_ready_o      = !buf_vld_q;
  assign buf_fill        = ex_valid_i && ex_ready_o && pop;
  assign protocol_err_o  = perr_q;

  // Write port source selection: load response, then skid buffer, then EX.
  always_comb begin
    rf_waddr_o = ex_waddr_i;
    rf_wdata_o = ex_wdata_i;
    we_raw     = 1'b0;
    if (pop) begin
      rf_waddr_o = fifo_q[rptr_q];
      rf_wdata_o = lsu_rdata_i;
      we_raw     = !lsu_err_i;
    end else if (buf_vld_q) begin
      rf_waddr_o = buf_waddr_q;
      rf_wdata_o = buf_wdata_q;
      we_raw     = 1'b1;
    end else if (ex_valid_i) begin
      we_raw     = 1'b1;
    end
  end

  assign rf_we_o = we_raw && !is_zero(rf_waddr_o);

  // Slot occupancy update; push and pop never target the same slot.
  always_comb begin
    slot_vld_nxt = slot_vld_q;
    if (pop)  slot_vld_nxt[rptr_q] = 1'b0;
    if (push) slot_vld_nxt[wptr_q] = 1'b1;
  end

  // Busy mask from pending load destinations and the parked EX destination.
  always_comb begin
    busy = '0;
    for (int i = 0; i < LsuDepth; i++) begin
      if (slot_vld_q[i] && !is_zero(fifo_q[i])) busy[fifo_q[i]] = 1'b1;
    end
    if (buf_vld_q && !is_zero(buf_waddr_q)) busy[buf_waddr_q] = 1'b1;
  end

  assign id_stall_o = (id_ra_used_i && busy[id_raddr_a_i]) ||
                      (id_rb_used_i && busy[id_raddr_b_i]) ||
                      (id_we_i      && busy[id_waddr_i])   ||
                      (ex_valid_i   && !ex_ready_o);

  // Control state: FIFO pointers/occupancy, skid valid and protocol error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      slot_vld_q <= '0;
      buf_vld_q  <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_nxt;
      if (pop)  rptr_q <= next_ptr(rptr_q);
      if (push) wptr_q <= next_ptr(wptr_q);
      if (buf_fill)                buf_vld_q <= 1'b1;
      else if (buf_vld_q && !pop)  buf_vld_q <= 1'b0;
      perr_q <= lsu_rvalid_i && fifo_empty;
    end
  end

  // Payload storage: load destinations and the parked EX result.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= lsu_waddr_i;
    if (buf_fill) begin
      buf_waddr_q <= ex_waddr_i;
      buf_wdata_q <= ex_wdata_i;
    end
  end

endmodule

// File: tb/tb_ibex_rf_writeback.sv
// Randomized scoreboard bench for ibex_rf_writeback with a queue-based reference model.
module tb_ibex_rf_writeback;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam bit RV32E = 1'b0;

  logic          clk = 1'b0, rst_ni = 1'b0;
  logic          ex_valid = 0, lsu_req = 0, lsu_rvalid = 0, lsu_err = 0;
  logic [4:0]    ex_waddr = 0, lsu_waddr = 0, ra = 0, rb = 0, wa = 0;
  logic [DW-1:0] ex_wdata = 0, lsu_rdata = 0;
  logic          ra_used = 0, rb_used = 0, id_we = 0;
  logic          ex_ready, lsu_req_ready, id_stall, rf_we, perr;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;

  ibex_rf_writeback #(.RV32E(RV32E), .DataWidth(DW), .LsuDepth(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
    .lsu_req_i(lsu_req), .lsu_req_ready_o(lsu_req_ready), .lsu_waddr_i(lsu_waddr),
    .lsu_rvalid_i(lsu_rvalid), .lsu_rdata_i(lsu_rdata), .lsu_err_i(lsu_err),
    .id_raddr_a_i(ra), .id_raddr_b_i(rb), .id_waddr_i(wa),
    .id_ra_used_i(ra_used), .id_rb_used_i(rb_used), .id_we_i(id_we), .id_stall_o(id_stall),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .rf_we_o(rf_we), .protocol_err_o(perr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [DW-1:0] d; } wr_t;

  // Reference model: pending load destinations in issue order plus one parked EX result.
  int            ld_q[$];
  bit            mvld = 0;
  logic [4:0]    maddr = 0;
  logic [DW-1:0] mdata = 0;
  bit            perr_next = 0;
  wr_t           exp_q[$];
  bit            e_exready, e_reqready, e_stall, e_perr;
  bit            chk_en = 0;
  int            nvec = 0, nerr = 0;

  function automatic bit mzero(logic [4:0] a);
    return (a == 0) || (RV32E && a[4]);
  endfunction

  function automatic bit mbusy(logic [4:0] a);
    if (mzero(a)) return 0;
    foreach (ld_q[i]) if (ld_q[i] == int'(a)) return 1;
    return mvld && (maddr == a);
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare handshake outputs each cycle and pop expected writes when the DUT writes.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ex_ready", ex_ready, e_exready);
      chk("lsu_req_ready", lsu_req_ready, e_reqready);
      chk("id_stall", id_stall, e_stall);
      chk("protocol_err", perr, e_perr);
      if (rf_we) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write_addr", {27'd0, rf_waddr}, 32'hDEAD);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("write_addr", {27'd0, rf_waddr}, {27'd0, w.a});
          chk("write_data", rf_wdata, w.d);
        end
      end
      chk("missed_writes", exp_q.size(), 0);
      exp_q.delete();
    end
  end

  task automatic step(input bit exv, input logic [4:0] exa, input logic [DW-1:0] exd,
                      input bit req, input logic [4:0] la,
                      input bit rv, input logic [DW-1:0] rd, input bit err,
                      input logic [4:0] a, input bit au, input logic [4:0] b, input bit bu,
                      input logic [4:0] w, input bit we);
    int sz0;
    @(posedge clk); #1;
    rst_ni = 1; ex_valid = exv; ex_waddr = exa; ex_wdata = exd;
    lsu_req = req; lsu_waddr = la; lsu_rvalid = rv; lsu_rdata = rd; lsu_err = err;
    ra = a; ra_used = au; rb = b; rb_used = bu; wa = w; id_we = we;
    sz0 = ld_q.size();
    e_exready  = !mvld;
    e_reqready = sz0 < DEPTH;
    e_stall    = (au && mbusy(a)) || (bu && mbusy(b)) || (we && mbusy(w)) || (exv && mvld);
    e_perr     = perr_next;
    perr_next  = rv && (sz0 == 0);
    if (rv && sz0 > 0) begin
      int d;
      d = ld_q.pop_front();
      if (!err && !mzero(5'(d))) exp_q.push_back('{5'(d), rd});
      if (exv && !mvld) begin mvld = 1; maddr = exa; mdata = exd; end
    end else if (mvld) begin
      if (!mzero(maddr)) exp_q.push_back('{maddr, mdata});
      mvld = 0;
    end else if (exv) begin
      if (!mzero(exa)) exp_q.push_back('{exa, exd});
    end
    if (req && sz0 < DEPTH) ld_q.push_back(int'(la));
    chk_en = 1;
  endtask

  task automatic idle(input logic [4:0] a, input bit au);
    step(0, 0, 0, 0, 0, 0, 0, 0, a, au, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_ni = 0; ex_valid = 0; lsu_req = 0; lsu_rvalid = 0; lsu_err = 0;
    ra_used = 0; rb_used = 0; id_we = 0;
    ld_q.delete(); exp_q.delete(); mvld = 0; perr_next = 0;
    e_exready = 1; e_reqready = 1; e_stall = 0; e_perr = 0;
    chk_en = 1;
    @(posedge clk); #1;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    do_reset();
    // EX-only write
    step(1, 5, 32'hA5A5_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Collision: load x3 response with EX x7 in the same cycle
    step(0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 7, 32'h2222, 0, 0, 1, 32'h1111, 0, 0, 0, 0, 0, 0, 0);
    idle(7, 1);
    // Scoreboard stall on load x9
    step(0, 0, 0, 1, 9, 0, 0, 0, 9, 1, 0, 0, 0, 0);
    repeat (3) idle(9, 1);
    step(0, 0, 0, 0, 0, 1, 32'h9999, 0, 9, 1, 0, 0, 0, 0);
    idle(9, 1);
    // FIFO full and in-order responses
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 10, 0, 0, 0, 6, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h4444, 0, 4, 1, 6, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h6666, 0, 0, 0, 0, 0, 6, 1);
    // Error response and x0 load
    step(0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h8888, 1, 8, 1, 0, 0, 0, 0);
    idle(8, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h0F0F, 0, 0, 1, 0, 0, 0, 0);
    // Spurious response with empty FIFO
    step(0, 0, 0, 0, 0, 1, 32'h5555, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    // Randomized traffic with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 1), raddr(), $urandom(),
           $urandom_range(0, 99) < 35, raddr(),
           $urandom_range(0, 99) < 40, $urandom(), $urandom_range(0, 9) == 0,
           raddr(), $urandom_range(0, 1), raddr(), $urandom_range(0, 1),
           raddr(), $urandom_range(0, 1));
    end
    idle(0, 0);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
